// File: rtl/core_pkg.sv
// Shared core definitions: RV32I opcodes, ALU operation encoding and the
// decoded control bundle carried down the pipeline.
package core_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_t;

    typedef struct packed {
        alu_op_t alu_op;
        logic    alu_src;
        logic    mem_read;
        logic    mem_write;
        logic    reg_write;
        logic    branch;
        logic    jump;
    } ctrl_t;

    // Map funct3 (plus the funct7[5] alternate bit) onto an ALU operation.
    function automatic alu_op_t alu_from_funct3(input logic [2:0] f3, input logic alt);
        alu_op_t op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/regfile.sv
// 32x32 integer register file: two asynchronous read ports, one write port,
// x0 hard-wired to zero and same-cycle write-to-read bypass.
module regfile (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2
);

    logic [31:0] mem [32];

    // Storage: cleared on reset, writes to x0 are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (waddr != 5'd0)) begin
            mem[waddr] <= wdata;
        end
    end

    // Read ports: x0 reads zero, a write landing this cycle is forwarded.
    always_comb begin
        rdata1 = mem[raddr1];
        rdata2 = mem[raddr2];
        if (raddr1 == 5'd0)
            rdata1 = '0;
        else if (we && (waddr == raddr1))
            rdata1 = wdata;
        if (raddr2 == 5'd0)
            rdata2 = '0;
        else if (we && (waddr == raddr2))
            rdata2 = wdata;
    end

endmodule

// File: rtl/decode.sv
// RV32I decode stage: combinational decode of the fetched word, register
// file read, load-use hazard detection and the ID pipeline register.
module decode
    import core_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] if_instr,
    input  logic [31:0] if_pc,
    input  logic        if_valid,
    input  logic        stall_in,
    input  logic        flush,
    input  logic        wb_we,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        stall_out,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_rs1_data,
    output logic [31:0] id_rs2_data,
    output logic [31:0] id_imm,
    output logic [4:0]  id_rs1,
    output logic [4:0]  id_rs2,
    output logic [4:0]  id_rd,
    output ctrl_t       id_ctrl,
    output logic        id_illegal
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] rs1_data, rs2_data;

    ctrl_t       dec_ctrl;
    logic        dec_illegal;
    logic [31:0] dec_imm;
    logic        use_rs1, use_rs2;
    logic        hazard;

    logic        vld_p1;
    logic [31:0] pc_p1, rs1_data_p1, rs2_data_p1, imm_p1;
    logic [4:0]  rs1_p1, rs2_p1, rd_p1;
    ctrl_t       ctrl_p1;
    logic        illegal_p1;

    assign opcode = if_instr[6:0];
    assign funct3 = if_instr[14:12];
    assign funct7 = if_instr[31:25];
    assign rs1    = if_instr[19:15];
    assign rs2    = if_instr[24:20];
    assign rd     = if_instr[11:7];

    regfile u_regfile (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (wb_we),
        .waddr  (wb_rd),
        .wdata  (wb_data),
        .raddr1 (rs1),
        .raddr2 (rs2),
        .rdata1 (rs1_data),
        .rdata2 (rs2_data)
    );

    // Instruction decode: control bundle, immediate, operand usage, legality.
    always_comb begin
        dec_ctrl    = '0;
        dec_illegal = 1'b0;
        dec_imm     = '0;
        use_rs1     = 1'b0;
        use_rs2     = 1'b0;
        case (opcode)
            OP_LUI: begin
                dec_imm            = {if_instr[31:12], 12'b0};
                dec_ctrl.alu_op    = ALU_PASSB;
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.reg_write = 1'b1;
            end
            OP_AUIPC: begin
                dec_imm            = {if_instr[31:12], 12'b0};
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.reg_write = 1'b1;
            end
            OP_JAL: begin
                dec_imm            = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12],
                                      if_instr[20], if_instr[30:21], 1'b0};
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.jump      = 1'b1;
            end
            OP_JALR: begin
                dec_imm            = {{20{if_instr[31]}}, if_instr[31:20]};
                use_rs1            = 1'b1;
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.jump      = 1'b1;
                dec_illegal        = (funct3 != 3'b000);
            end
            OP_BRANCH: begin
                dec_imm            = {{19{if_instr[31]}}, if_instr[31], if_instr[7],
                                      if_instr[30:25], if_instr[11:8], 1'b0};
                use_rs1            = 1'b1;
                use_rs2            = 1'b1;
                dec_ctrl.alu_op    = ALU_SUB;
                dec_ctrl.branch    = 1'b1;
                dec_illegal        = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            OP_LOAD: begin
                dec_imm            = {{20{if_instr[31]}}, if_instr[31:20]};
                use_rs1            = 1'b1;
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.mem_read  = 1'b1;
                dec_ctrl.reg_write = 1'b1;
                dec_illegal        = (funct3 == 3'b011) || (funct3 == 3'b110) ||
                                     (funct3 == 3'b111);
            end
            OP_STORE: begin
                dec_imm            = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
                use_rs1            = 1'b1;
                use_rs2            = 1'b1;
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.mem_write = 1'b1;
                dec_illegal        = (funct3 > 3'b010);
            end
            OP_IMM: begin
                dec_imm            = {{20{if_instr[31]}}, if_instr[31:20]};
                use_rs1            = 1'b1;
                dec_ctrl.alu_op    = alu_from_funct3(funct3, (funct3 == 3'b101) && funct7[5]);
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.reg_write = 1'b1;
                if (funct3 == 3'b001)
                    dec_illegal = (funct7 != 7'b0000000);
                else if (funct3 == 3'b101)
                    dec_illegal = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
            end
            OP_REG: begin
                use_rs1            = 1'b1;
                use_rs2            = 1'b1;
                dec_ctrl.alu_op    = alu_from_funct3(funct3, funct7[5]);
                dec_ctrl.reg_write = 1'b1;
                dec_illegal        = !((funct7 == 7'b0000000) ||
                                       ((funct7 == 7'b0100000) &&
                                        ((funct3 == 3'b000) || (funct3 == 3'b101))));
            end
            OP_FENCE: begin
                dec_illegal = (funct3 != 3'b000);
            end
            OP_SYSTEM: begin
                // Only ECALL and EBREAK belong to the base set.
                dec_illegal = (if_instr[31:7] != 25'h0) && (if_instr[31:7] != 25'h2000);
            end
            default: begin
                dec_illegal = 1'b1;
            end
        endcase
        if (dec_illegal) begin
            dec_ctrl.reg_write = 1'b0;
            dec_ctrl.mem_read  = 1'b0;
            dec_ctrl.mem_write = 1'b0;
            dec_ctrl.branch    = 1'b0;
            dec_ctrl.jump      = 1'b0;
        end
    end

    // Load-use hazard: a load in ID whose destination feeds the incoming word.
    always_comb begin
        hazard = vld_p1 && ctrl_p1.mem_read && (rd_p1 != 5'd0) && if_valid &&
                 ((use_rs1 && (rs1 == rd_p1)) || (use_rs2 && (rs2 == rd_p1)));
    end

    assign stall_out = hazard || stall_in;

    // ---- stage boundary: IF -> ID pipeline register ----
    // ID register: flush clears, stall_in holds, hazard inserts a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1      <= 1'b0;
            pc_p1       <= '0;
            rs1_data_p1 <= '0;
            rs2_data_p1 <= '0;
            imm_p1      <= '0;
            rs1_p1      <= '0;
            rs2_p1      <= '0;
            rd_p1       <= '0;
            ctrl_p1     <= '0;
            illegal_p1  <= 1'b0;
        end else if (flush || (!stall_in && hazard)) begin
            vld_p1     <= 1'b0;
            ctrl_p1    <= '0;
            illegal_p1 <= 1'b0;
        end else if (!stall_in) begin
            vld_p1      <= if_valid;
            pc_p1       <= if_pc;
            rs1_data_p1 <= rs1_data;
            rs2_data_p1 <= rs2_data;
            imm_p1      <= dec_imm;
            rs1_p1      <= rs1;
            rs2_p1      <= rs2;
            rd_p1       <= rd;
            ctrl_p1     <= if_valid ? dec_ctrl : '0;
            illegal_p1  <= if_valid && dec_illegal;
        end
    end

    assign id_valid    = vld_p1;
    assign id_pc       = pc_p1;
    assign id_rs1_data = rs1_data_p1;
    assign id_rs2_data = rs2_data_p1;
    assign id_imm      = imm_p1;
    assign id_rs1      = rs1_p1;
    assign id_rs2      = rs2_p1;
    assign id_rd       = rd_p1;
    assign id_ctrl     = ctrl_p1;
    assign id_illegal  = illegal_p1;

endmodule
